// File: rtl/myproject_mac_pipe_p.sv
`default_nettype none
// ============================================================================
// Module   : myproject_mac_pipe_p
// Purpose  : Pipelined multiply-accumulate unit with valid-tagged product
//            pipeline and framed accumulator. Each term is multiplied
//            (din0 signed, din1 signed or unsigned), delayed through
//            NUM_STAGE registers, then accumulated. The frame sum is
//            published one register later.
// Ports    : clk, reset (async, active-high), ce (global clock enable)
//            in_valid/in_first/in_last/din0/din1 : term input
//            out_valid/dout/term_cnt             : completed frame result
//            busy : frame open or any term in flight
//            ovf  : sticky saturation flag
// Options  : MYPROJECT_MAC_SAT_EN - saturating accumulation with sticky ovf;
//            when undefined accumulation wraps and ovf is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module myproject_mac_pipe_p #(
  parameter int DIN0_WIDTH  = 16,
  parameter int DIN1_WIDTH  = 8,
  parameter int DIN1_SIGNED = 0,
  parameter int NUM_STAGE   = 2,
  parameter int ACC_WIDTH   = 32,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic                  out_valid,
  output logic [ACC_WIDTH-1:0]  dout,
  output logic [CNT_WIDTH-1:0]  term_cnt,
  output logic                  busy,
  output logic                  ovf
);

  localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Operand conditioning and product
  // --------------------------------------------------------------------------
  logic [DIN1_WIDTH:0] din1_ext;

  generate
    if (DIN1_SIGNED != 0) begin : g_din1_signed
      assign din1_ext = {din1[DIN1_WIDTH-1], din1};
    end else begin : g_din1_unsigned
      assign din1_ext = {1'b0, din1};
    end
  endgenerate

  // Both operands are sign-extended to the full product width; the low
  // PROD_WIDTH bits of that product are the exact signed result.
  logic [PROD_WIDTH-1:0] op0;
  logic [PROD_WIDTH-1:0] op1;
  logic [PROD_WIDTH-1:0] prod_in;

  assign op0     = {{(PROD_WIDTH-DIN0_WIDTH){din0[DIN0_WIDTH-1]}}, din0};
  assign op1     = {{DIN0_WIDTH{din1_ext[DIN1_WIDTH]}}, din1_ext};
  assign prod_in = op0 * op1;

  // --------------------------------------------------------------------------
  // Product pipeline with sideband tags
  // --------------------------------------------------------------------------
  logic [PROD_WIDTH-1:0] prod_pipe [NUM_STAGE];
  logic [NUM_STAGE-1:0]  vld_pipe;
  logic [NUM_STAGE-1:0]  first_pipe;
  logic [NUM_STAGE-1:0]  last_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STAGE; i++) prod_pipe[i] <= '0;
      vld_pipe   <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
    end else if (ce) begin
      prod_pipe[0]  <= prod_in;
      vld_pipe[0]   <= in_valid;
      first_pipe[0] <= in_first;
      last_pipe[0]  <= in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        prod_pipe[i]  <= prod_pipe[i-1];
        vld_pipe[i]   <= vld_pipe[i-1];
        first_pipe[i] <= first_pipe[i-1];
        last_pipe[i]  <= last_pipe[i-1];
      end
    end
  end

  logic                  term_vld;
  logic                  term_first;
  logic                  term_last;
  logic [PROD_WIDTH-1:0] prod_out;
  logic [ACC_WIDTH-1:0]  prod_acc;

  assign term_vld   = vld_pipe[NUM_STAGE-1];
  assign term_first = first_pipe[NUM_STAGE-1];
  assign term_last  = last_pipe[NUM_STAGE-1];
  assign prod_out   = prod_pipe[NUM_STAGE-1];

  // Bring the product to accumulator width. A narrower accumulator keeps the
  // low bits, which is exact whenever the product fits.
  generate
    if (ACC_WIDTH > PROD_WIDTH) begin : g_ext_sign
      assign prod_acc = {{(ACC_WIDTH-PROD_WIDTH){prod_out[PROD_WIDTH-1]}}, prod_out};
    end else if (ACC_WIDTH == PROD_WIDTH) begin : g_ext_none
      assign prod_acc = prod_out;
    end else begin : g_ext_trunc
      assign prod_acc = prod_out[ACC_WIDTH-1:0];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Accumulate adder
  // --------------------------------------------------------------------------
  state_t               state;
  state_t               state_nxt;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_nxt;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 emit_pend;
  logic                 emit_nxt;

`ifdef MYPROJECT_MAC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH:0] sum_wide;
  logic               sat_hit;
  logic               sat_nxt;
  logic               ovf_flag;

  // One guard bit: overflow when the two top bits disagree; the guard bit
  // carries the true sign and so selects the clamp direction.
  assign sum_wide = {acc[ACC_WIDTH-1], acc} + {prod_acc[ACC_WIDTH-1], prod_acc};
  assign sat_hit  = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
  assign acc_sum  = !sat_hit ? sum_wide[ACC_WIDTH-1:0]
                  : (sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX);
  assign ovf      = ovf_flag;
`else
  assign acc_sum = acc + prod_acc;
  assign ovf     = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    emit_nxt  = 1'b0;
`ifdef MYPROJECT_MAC_SAT_EN
    sat_nxt   = 1'b0;
`endif
    if (term_vld) begin
      if (term_first) begin
        // New frame; in ACC this silently abandons the open frame.
        acc_nxt   = prod_acc;
        cnt_nxt   = CNT_ONE;
        emit_nxt  = term_last;
        state_nxt = term_last ? IDLE : ACC;
      end else if (state == ACC) begin
        acc_nxt   = acc_sum;
        cnt_nxt   = cnt + CNT_ONE;
        emit_nxt  = term_last;
        state_nxt = term_last ? IDLE : ACC;
`ifdef MYPROJECT_MAC_SAT_EN
        sat_nxt   = sat_hit;
`endif
      end
      // IDLE without first: the term is dropped.
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      emit_pend <= 1'b0;
      out_valid <= 1'b0;
      dout      <= '0;
      term_cnt  <= '0;
    end else if (ce) begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      emit_pend <= emit_nxt;
      // Result register: acc/cnt still hold the closed frame here.
      out_valid <= emit_pend;
      if (emit_pend) begin
        dout     <= acc;
        term_cnt <= cnt;
      end
    end
  end

`ifdef MYPROJECT_MAC_SAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_flag <= 1'b0;
    end else if (ce && sat_nxt) begin
      ovf_flag <= 1'b1;
    end
  end
`endif

  // emit_pend counts as in flight so busy covers the frame until out_valid.
  assign busy = (state == ACC) || (|vld_pipe) || emit_pend;

endmodule
`default_nettype wire

// File: tb/tb_myproject_mac_pipe_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_myproject_mac_pipe_p
// Purpose  : Directed self-checking bench for myproject_mac_pipe_p. Three
//            instances share the stimulus: default (unsigned din1), signed
//            din1, and a 24-bit accumulator for overflow behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_myproject_mac_pipe_p;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        in_valid;
  logic        in_first;
  logic        in_last;
  logic [15:0] din0;
  logic [7:0]  din1;

  logic        ov_a, busy_a, ovf_a;
  logic [31:0] dout_a;
  logic [7:0]  tc_a;
  logic        ov_s, busy_s, ovf_s;
  logic [31:0] dout_s;
  logic [7:0]  tc_s;
  logic        ov_w, busy_w, ovf_w;
  logic [23:0] dout_w;
  logic [7:0]  tc_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  myproject_mac_pipe_p dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0),
    .din1(din1), .in_first(in_first), .in_last(in_last), .out_valid(ov_a),
    .dout(dout_a), .term_cnt(tc_a), .busy(busy_a), .ovf(ovf_a)
  );

  myproject_mac_pipe_p #(.DIN1_SIGNED(1)) dut_s (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0),
    .din1(din1), .in_first(in_first), .in_last(in_last), .out_valid(ov_s),
    .dout(dout_s), .term_cnt(tc_s), .busy(busy_s), .ovf(ovf_s)
  );

  myproject_mac_pipe_p #(.ACC_WIDTH(24)) dut_w (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0),
    .din1(din1), .in_first(in_first), .in_last(in_last), .out_valid(ov_w),
    .dout(dout_w), .term_cnt(tc_w), .busy(busy_w), .ovf(ovf_w)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [15:0] a, input logic [7:0] b,
                      input logic f, input logic l);
    din0 = a; din1 = b; in_first = f; in_last = l; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  // Bounded wait for out_valid; n is the number of ce edges taken.
  task automatic wait_out(output int n);
    n = 0;
    while (!ov_a && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    din0 = '0; din1 = '0;
    step(); step();
    checks++;
    if ({ov_a, busy_a, ovf_a, dout_a, tc_a} !== '0) begin
      errors++; $display("FAIL reset_a: got ov=%0b busy=%0b ovf=%0b dout=%0d cnt=%0d expected all 0",
                         ov_a, busy_a, ovf_a, dout_a, tc_a);
    end
    checks++;
    if ({ov_w, busy_w, ovf_w, dout_w, tc_w} !== '0) begin
      errors++; $display("FAIL reset_w: got ov=%0b busy=%0b ovf=%0b dout=%0d cnt=%0d expected all 0",
                         ov_w, busy_w, ovf_w, dout_w, tc_w);
    end
    #3 reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    int n;
    send(16'(-3), 8'd200, 1'b1, 1'b1);
    wait_out(n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL single_latency: got %0d expected 3", n); end
    checks++;
    if (dout_a !== 32'(-600)) begin
      errors++; $display("FAIL single_dout: got %0d expected -600", $signed(dout_a));
    end
    checks++;
    if (tc_a !== 8'd1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", tc_a); end
    step();
    checks++;
    if (ov_a !== 1'b0 || dout_a !== 32'(-600)) begin
      errors++; $display("FAIL single_pulse_hold: got ov=%0b dout=%0d expected ov=0 dout=-600",
                         ov_a, $signed(dout_a));
    end
  endtask

  task automatic test_frame();
    int n;
    logic [15:0] a [4];
    logic [7:0]  b [4];
    a = '{16'd100, 16'(-50), 16'd7, 16'(-1)};
    b = '{8'd2, 8'd4, 8'd255, 8'd1};
    for (int i = 0; i < 4; i++) begin
      send(a[i], b[i], i == 0, i == 3);
      checks++;
      if (busy_a !== 1'b1) begin errors++; $display("FAIL frame_busy_in term%0d: got %0b expected 1", i, busy_a); end
    end
    n = 0;
    while (!ov_a && n < 20) begin
      checks++;
      if (busy_a !== 1'b1) begin errors++; $display("FAIL frame_busy_wait: got %0b expected 1", busy_a); end
      step();
      n++;
    end
    checks++;
    if (n !== 3) begin errors++; $display("FAIL frame_latency: got %0d expected 3", n); end
    checks++;
    if (dout_a !== 32'd1784 || tc_a !== 8'd4) begin
      errors++; $display("FAIL frame_result: got dout=%0d cnt=%0d expected 1784/4", $signed(dout_a), tc_a);
    end
  endtask

  task automatic test_signedness();
    int n;
    send(16'h8000, 8'h80, 1'b1, 1'b1);
    wait_out(n);
    checks++;
    if (dout_a !== 32'(-4194304)) begin
      errors++; $display("FAIL unsigned_din1: got %0d expected -4194304", $signed(dout_a));
    end
    checks++;
    if (ov_s !== 1'b1 || dout_s !== 32'd4194304) begin
      errors++; $display("FAIL signed_din1: got ov=%0b dout=%0d expected 1/4194304", ov_s, $signed(dout_s));
    end
  endtask

  task automatic test_ce_gap();
    int n;
    send(16'd10, 8'd1, 1'b1, 1'b0);
    // Frozen cycles with garbage presented; none of it may be sampled.
    ce = 1'b0; in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; din0 = 16'd99; din1 = 8'd99;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (ov_a !== 1'b0 || busy_a !== 1'b1) begin
        errors++; $display("FAIL ce_freeze_mid: got ov=%0b busy=%0b expected 0/1", ov_a, busy_a);
      end
    end
    ce = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    step(); step(); step();
    send(16'd20, 8'd2, 1'b0, 1'b0);
    send(16'd30, 8'd3, 1'b0, 1'b1);
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (ov_a !== 1'b0) begin errors++; $display("FAIL ce_freeze_tail: got ov=%0b expected 0", ov_a); end
    end
    ce = 1'b1;
    wait_out(n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL ce_latency: got %0d expected 3", n); end
    checks++;
    if (dout_a !== 32'd140 || tc_a !== 8'd3) begin
      errors++; $display("FAIL ce_result: got dout=%0d cnt=%0d expected 140/3", $signed(dout_a), tc_a);
    end
  endtask

  task automatic test_async_reset();
    int n;
    send(16'd5, 8'd5, 1'b1, 1'b0);
    send(16'd5, 8'd5, 1'b0, 1'b0);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({ov_a, busy_a, ovf_a, dout_a, tc_a} !== '0) begin
      errors++; $display("FAIL async_reset: got ov=%0b busy=%0b dout=%0d cnt=%0d expected all 0",
                         ov_a, busy_a, $signed(dout_a), tc_a);
    end
    #2 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (ov_a !== 1'b0) begin errors++; $display("FAIL reset_discard: got ov=%0b expected 0", ov_a); end
    end
    send(16'd7, 8'd3, 1'b1, 1'b1);
    wait_out(n);
    checks++;
    if (n !== 3 || dout_a !== 32'd21 || tc_a !== 8'd1) begin
      errors++; $display("FAIL post_reset: got lat=%0d dout=%0d cnt=%0d expected 3/21/1", n, $signed(dout_a), tc_a);
    end
  endtask

  task automatic test_drop_restart();
    int n;
    send(16'd9, 8'd9, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (ov_a !== 1'b0) begin errors++; $display("FAIL drop_no_first: got ov=%0b expected 0", ov_a); end
    end
    send(16'd1, 8'd1, 1'b1, 1'b0);
    send(16'd2, 8'd2, 1'b0, 1'b0);
    send(16'd3, 8'd3, 1'b1, 1'b0);
    send(16'd4, 8'd4, 1'b0, 1'b1);
    wait_out(n);
    checks++;
    if (dout_a !== 32'd25 || tc_a !== 8'd2) begin
      errors++; $display("FAIL restart: got dout=%0d cnt=%0d expected 25/2", $signed(dout_a), tc_a);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    send(16'd2, 8'd3, 1'b1, 1'b1);
    send(16'd4, 8'd5, 1'b1, 1'b1);
    wait_out(n);
    checks++;
    if (n !== 2 || dout_a !== 32'd6 || tc_a !== 8'd1) begin
      errors++; $display("FAIL b2b_first: got lat=%0d dout=%0d cnt=%0d expected 2/6/1", n, $signed(dout_a), tc_a);
    end
    step();
    checks++;
    if (ov_a !== 1'b1 || dout_a !== 32'd20) begin
      errors++; $display("FAIL b2b_second: got ov=%0b dout=%0d expected 1/20", ov_a, $signed(dout_a));
    end
  endtask

  task automatic test_cnt_wrap();
    int n;
    for (int i = 0; i <= 256; i++) send(16'd1, 8'd1, i == 0, i == 256);
    wait_out(n);
    checks++;
    if (n !== 3 || dout_a !== 32'd257 || tc_a !== 8'd1) begin
      errors++; $display("FAIL cnt_wrap: got lat=%0d dout=%0d cnt=%0d expected 3/257/1", n, $signed(dout_a), tc_a);
    end
  endtask

  task automatic test_overflow();
    int n;
    logic [23:0] exp_w;
    logic        exp_ovf;
`ifdef MYPROJECT_MAC_SAT_EN
    exp_w = 24'd8388607; exp_ovf = 1'b1;
`else
    exp_w = 24'd8289539; exp_ovf = 1'b0;
`endif
    for (int i = 0; i < 3; i++) send(16'd32767, 8'd255, i == 0, i == 2);
    wait_out(n);
    checks++;
    if (ov_w !== 1'b1 || dout_w !== exp_w || ovf_w !== exp_ovf) begin
      errors++; $display("FAIL acc24_overflow: got ov=%0b dout=%0d ovf=%0b expected 1/%0d/%0b",
                         ov_w, dout_w, ovf_w, exp_w, exp_ovf);
    end
    checks++;
    if (dout_a !== 32'd25066755 || ovf_a !== 1'b0) begin
      errors++; $display("FAIL acc32_no_overflow: got dout=%0d ovf=%0b expected 25066755/0", $signed(dout_a), ovf_a);
    end
    send(16'd1, 8'd1, 1'b1, 1'b1);
    wait_out(n);
    checks++;
    if (dout_w !== 24'd1 || ovf_w !== exp_ovf) begin
      errors++; $display("FAIL ovf_sticky: got dout=%0d ovf=%0b expected 1/%0b", dout_w, ovf_w, exp_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_frame();
    test_signedness();
    test_ce_gap();
    test_async_reset();
    test_drop_restart();
    test_back_to_back();
    test_cnt_wrap();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
